// File: rtl/rtc_time_keeper_if.sv
// Signal bundle for rtc_time_keeper: time-set inputs, pause level, time/strobe outputs and alarm.
// The alarm members exist in every build; they only carry meaning when RTC_ALARM_EN is defined.
interface rtc_time_keeper_if;
    logic       load;
    logic [7:0] hour_in;
    logic [7:0] min_in;
    logic [7:0] sec_in;
    logic       pause;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       sec_pulse;
    logic       day_wrap;
    logic [7:0] alarm_hour;
    logic [7:0] alarm_min;
    logic       alarm_clr;
    logic       alarm_out;

    modport master (
        output load, hour_in, min_in, sec_in, pause,
        output alarm_hour, alarm_min, alarm_clr,
        input  hour, min, sec, sec_pulse, day_wrap, alarm_out
    );

    modport slave (
        input  load, hour_in, min_in, sec_in, pause,
        input  alarm_hour, alarm_min, alarm_clr,
        output hour, min, sec, sec_pulse, day_wrap, alarm_out
    );
endinterface

// File: rtl/rtc_time_keeper.sv
// Real-time clock core: divides clk to a 1 Hz tick and keeps binary 24 h hour:min:sec.
// Optional alarm comparator is built only when the macro RTC_ALARM_EN is defined.
module rtc_time_keeper #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    rtc_time_keeper_if.slave bus
);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    function automatic logic [7:0] clamp_hour(input logic [7:0] v);
        return (v > 8'd23) ? 8'd0 : v;
    endfunction

    function automatic logic [7:0] clamp_min_sec(input logic [7:0] v);
        return (v > 8'd59) ? 8'd0 : v;
    endfunction

    logic [CNT_W-1:0] r_presc;
    logic [7:0]       r_hour;
    logic [7:0]       r_min;
    logic [7:0]       r_sec;
    logic             r_sec_pulse;
    logic             r_day_wrap;

    logic             w_tick;
    logic             w_adv;
    logic             w_sec_wrap;
    logic             w_min_wrap;
    logic             w_at_eod;
    logic [7:0]       w_hour_nx;
    logic [7:0]       w_min_nx;
    logic [7:0]       w_sec_nx;

    // A tick coinciding with a load is dropped; w_adv is the tick that really advances time.
    assign w_tick     = (r_presc == PRESC_LAST) && !bus.pause;
    assign w_adv      = w_tick && !bus.load;
    assign w_sec_wrap = (r_sec == 8'd59);
    assign w_min_wrap = w_sec_wrap && (r_min == 8'd59);
    assign w_at_eod   = w_min_wrap && (r_hour == 8'd23);

    always_comb begin
        w_sec_nx  = r_sec + 8'd1;
        w_min_nx  = r_min;
        w_hour_nx = r_hour;
        if (w_sec_wrap) begin
            w_sec_nx = 8'd0;
            w_min_nx = r_min + 8'd1;
            if (w_min_wrap) begin
                w_min_nx  = 8'd0;
                w_hour_nx = (r_hour == 8'd23) ? 8'd0 : r_hour + 8'd1;
            end
        end
    end

    // Load restarts the prescaler so a full second follows every newly set time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (bus.load || w_tick) begin
            r_presc <= '0;
        end else if (!bus.pause) begin
            r_presc <= r_presc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hour <= 8'd0;
            r_min  <= 8'd0;
            r_sec  <= 8'd0;
        end else if (bus.load) begin
            r_hour <= clamp_hour(bus.hour_in);
            r_min  <= clamp_min_sec(bus.min_in);
            r_sec  <= clamp_min_sec(bus.sec_in);
        end else if (w_adv) begin
            r_hour <= w_hour_nx;
            r_min  <= w_min_nx;
            r_sec  <= w_sec_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_pulse <= 1'b0;
            r_day_wrap  <= 1'b0;
        end else begin
            r_sec_pulse <= w_adv;
            r_day_wrap  <= w_adv && w_at_eod;
        end
    end

    assign bus.hour      = r_hour;
    assign bus.min       = r_min;
    assign bus.sec       = r_sec;
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.day_wrap  = r_day_wrap;

`ifdef RTC_ALARM_EN
    logic       r_alarm;
    logic [5:0] r_ring_cnt;
    logic       w_alarm_ok;
    logic       w_alarm_hit;

    // Only an advancing tick can hit, so loading the alarm time itself never rings.
    assign w_alarm_ok  = (bus.alarm_hour <= 8'd23) && (bus.alarm_min <= 8'd59);
    assign w_alarm_hit = w_adv && w_alarm_ok &&
                         (w_hour_nx == bus.alarm_hour) &&
                         (w_min_nx  == bus.alarm_min)  &&
                         (w_sec_nx  == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm    <= 1'b0;
            r_ring_cnt <= 6'd0;
        end else if (bus.alarm_clr) begin
            r_alarm    <= 1'b0;
            r_ring_cnt <= 6'd0;
        end else if (w_alarm_hit) begin
            r_alarm    <= 1'b1;
            r_ring_cnt <= 6'd0;
        end else if (r_alarm && w_adv) begin
            if (r_ring_cnt == 6'd59) begin
                r_alarm    <= 1'b0;
                r_ring_cnt <= 6'd0;
            end else begin
                r_ring_cnt <= r_ring_cnt + 6'd1;
            end
        end
    end

    assign bus.alarm_out = r_alarm;
`else
    logic w_unused_alarm;

    assign w_unused_alarm = ^{bus.alarm_hour, bus.alarm_min, bus.alarm_clr};
    assign bus.alarm_out  = 1'b0;
`endif

endmodule
